fp_reduction_tree: RTL
======================

# fp_reduction_tree

Parametrised single-precision floating-point reduction tree. Sums NI packed 32-bit IEEE-754 operands into one result using pairwise levels of `adder_subtractor_with_start` instances chained by start/finish handshakes. Optional multi-beat accumulation folds successive input vectors into one sum, for dot-product rows longer than NI. Sits behind the matrix-vector multiplier array and feeds the solver update stage.

## Interface

Parameters:
- NI, 16, number of 32-bit operands per beat; any value ≥ 2, not restricted to powers of two.
- ACC_EN, 1, enables the multi-beat accumulate stage. When 0, `first` and `last` are ignored and every beat is treated as first and last.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only while `ready` = 1.
- first  in  1  qualifies `start`: this beat opens a new accumulation.
- last  in  1  qualifies `start`: this beat closes the accumulation.
- inputs  in  NI*32  operands; operand i occupies bits [32i+31:32i]. Captured on the accepted `start`.
- ready  out  1  block can accept a `start`.
- summation  out  32  result; held stable from `finish` until the next `finish`.
- finish  out  1  one-cycle pulse marking a valid `summation`.
- finish_dash  out  1  `finish` delayed by one clock.

## Operation

- Tree has L = ceil(log2 NI) levels; level k has n_k operands, with n_0 = NI and n_{k+1} = ceil(n_k/2).
- Odd operand at any level is paired with +0.0 (32'h0000_0000) and goes through a real adder, so all lanes share one timing.
- Each level owns a sticky join register with one bit per adder:
  - a bit sets on its adder's `finish` pulse;
  - when all bits are set, the next level's start is driven that cycle and the register clears on the next edge.
- Level 0 adders start on the accepted `start`. Inputs are registered, so the caller may change `inputs` after acceptance.
- Control FSM states:
  - IDLE: `ready` = 1.
    - Accepted start → TREE.
  - TREE: `ready` = 0.
    - Root finish with ACC_EN = 1 → ACC.
    - Root finish with ACC_EN = 0 → DONE.
  - ACC: `ready` = 0.
    - If `first` was captured, the accumulator loads the root sum directly; this takes 1 cycle.
    - Otherwise a dedicated adder computes acc + root.
    - → DONE when the load or add completes.
  - DONE: lasts 1 cycle.
    - If `last` was captured (or ACC_EN = 0): `summation` ← result and `finish` pulses.
    - → IDLE in all cases.
- Only one beat is in flight at a time; there is no overlap between beats.
- `start` while `ready` = 0 is ignored, with no side effects.
- A non-first beat with no open accumulation (after reset or after a `last`) is treated as first.
- `first` and `last` both set on one beat gives a single-beat sum.

## Timing

- TA = fixed start-to-finish latency of `adder_subtractor_with_start`, held as package constant FP_ADD_LAT.
- Per tree level: TA + 1 cycles (join register included).
- `start` accepted at cycle t:
  - root result at t + L·(TA+1);
  - `finish` pulses at t + L·(TA+1) + 1 when ACC_EN = 0;
  - `finish` pulses at t + L·(TA+1) + TA + 2 for a non-first beat with ACC_EN = 1.
- `ready` rises in the cycle after `finish` (or after DONE on a non-last beat).
- Reset values: `ready` = 1, `summation` = 0, `finish` = 0, `finish_dash` = 0; all join registers, the accumulator and the open-accumulation flag = 0; FSM in IDLE.
- Reset mid-operation aborts the beat. No `finish` is issued for that beat, and in-flight adder finishes arriving after reset are ignored, because the join registers only set in TREE.

## Structure

- Package `fp_reduce_pkg` holds:
  - FP_WIDTH = 32;
  - FP_ZERO = 32'h0000_0000;
  - FP_ADD_LAT;
  - a constant function for level count and per-level width;
  - the FSM state enum {IDLE, TREE, ACC, DONE}.
- Sub-module `reduction_level`:
  - parameter N;
  - generates ceil(N/2) adders, the zero padding and the sticky join register;
  - outputs ceil(N/2) sums plus a `level_done` strobe.
- Top level generates L `reduction_level` instances, plus the accumulate adder and the FSM.

## Test plan

- NI = 16, ACC_EN = 0, all operands 32'h3F80_0000 (1.0) → `summation` = 32'h4180_0000 (16.0); `finish` exactly at t + 4·(TA+1) + 1; `finish_dash` one cycle later.
- NI = 5, operands 1.0, 2.0, 3.0, 4.0, 5.0 → 32'h4170_0000 (15.0); checks the zero-padded odd lanes across all 3 levels.
- NI = 16, ACC_EN = 1, three beats of sixteen 1.0 flagged first / –/ last → exactly one `finish`, `summation` = 32'h4240_0000 (48.0); `ready` re-rises between beats.
- `start` pulsed again while `ready` = 0 with different `inputs` → ignored; result unchanged (16.0).
- `rst` asserted mid-TREE, then a fresh single beat of eight 2.0 (NI = 8) → no `finish` for the aborted beat; then 32'h4180_0000 (16.0).
- Operands pairwise x, −x (1.5 / −1.5 in all lanes) → 32'h0000_0000; `finish` timing unchanged.

Source files
------------

// File: rtl/fp_reduce_pkg.sv
// fp_reduce_pkg: shared constants, tree-shape helpers and FSM states for the fp reduction tree
package fp_reduce_pkg;
  localparam int FP_WIDTH = 32;
  localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
  localparam int FP_ADD_LAT = 3;
  typedef enum logic [1:0] {IDLE, TREE, ACC, DONE} state_t;
  function automatic int lvl_width(int n, int k);
    int m = n;
    for (int i = 0; i < k; i++) m = (m + 1) / 2;
    return m;
  endfunction
  function automatic int lvl_count(int n);
    int l = 0;
    for (int m = n; m > 1; m = (m + 1) / 2) l++;
    return l;
  endfunction
endpackage

// File: rtl/adder_subtractor_with_start.sv
// adder_subtractor_with_start: single-precision add/sub, round-to-nearest-even, fixed FP_ADD_LAT latency
module adder_subtractor_with_start
  import fp_reduce_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sub,
  input  logic [FP_WIDTH-1:0] a,
  input  logic [FP_WIDTH-1:0] b,
  output logic [FP_WIDTH-1:0] sum,
  output logic                finish
);
  logic [FP_WIDTH-1:0] a_q, b_q;
  logic [FP_ADD_LAT-1:0] v;
  function automatic logic [31:0] fadd(logic [31:0] x, logic [31:0] y);
    logic [31:0] p, q;
    logic [7:0] ep, eq, d, dd;
    logic [23:0] mp, mq;
    logic [53:0] w;
    logic [26:0] yq, n;
    logic [27:0] s;
    logic [24:0] mr;
    logic [9:0] e;
    logic up;
    int lz, sh;
    if (&x[30:23] || &y[30:23]) begin
      if (&x[30:23] && &y[30:23] && x[22:0] == 0 && y[22:0] == 0 && x[31] != y[31]) return 32'h7FC0_0000;
      return &x[30:23] ? x : y;
    end
    {p, q} = (x[30:0] < y[30:0]) ? {y, x} : {x, y};
    ep = (p[30:23] == 0) ? 8'd1 : p[30:23];
    eq = (q[30:23] == 0) ? 8'd1 : q[30:23];
    mp = {|p[30:23], p[22:0]};
    mq = {|q[30:23], q[22:0]};
    d = ep - eq;
    dd = (d > 8'd31) ? 8'd31 : d;
    w = {mq, 30'b0} >> dd;
    yq = {w[53:28], |w[27:0]};
    s = (p[31] == q[31]) ? {1'b0, mp, 3'b0} + {1'b0, yq} : {1'b0, mp, 3'b0} - {1'b0, yq};
    if (s == 0) return (p[31] & q[31]) ? 32'h8000_0000 : 32'h0000_0000;
    if (s[27]) begin
      n = {s[27:2], |s[1:0]};
      e = {2'b0, ep} + 10'd1;
    end else begin
      lz = 0;
      for (int i = 0; i <= 26; i++) if (s[i]) lz = 26 - i;
      sh = (lz < int'(ep)) ? lz : int'(ep) - 1;
      n = s[26:0] << sh;
      e = {2'b0, ep} - 10'(sh);
    end
    up = n[2] & (n[1] | n[0] | n[3]);
    mr = {1'b0, n[26:3]} + 25'(up);
    if (mr[24]) begin
      mr = mr >> 1;
      e = e + 10'd1;
    end
    if (!mr[23]) e = 10'd0;
    if (e >= 10'd255) return {p[31], 8'hFF, 23'h0};
    return {p[31], e[7:0], mr[22:0]};
  endfunction
  // capture operands on start, walk the valid token down the pipe, land the sum just before finish
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      v <= '0;
      sum <= '0;
    end else begin
      v <= {v[FP_ADD_LAT-2:0], start};
      if (start) begin
        a_q <= a;
        b_q <= {b[31] ^ sub, b[30:0]};
      end
      if (v[FP_ADD_LAT-2]) sum <= fadd(a_q, b_q);
    end
  assign finish = v[FP_ADD_LAT-1];
endmodule

// File: rtl/reduction_level.sv
// reduction_level: one pairwise tree level of ceil(N/2) adders joined by a sticky done register
module reduction_level
  import fp_reduce_pkg::*;
#(
  parameter int N = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             en,
  input  logic [N*FP_WIDTH-1:0]            ops,
  output logic [((N+1)/2)*FP_WIDTH-1:0]    sums,
  output logic                             level_done
);
  localparam int M = (N + 1) / 2;
  logic [M-1:0] fin, join_q;
  for (genvar j = 0; j < M; j++) begin : g_add
    logic [FP_WIDTH-1:0] b;
    if (2 * j + 1 < N) begin : g_pair
      assign b = ops[(2*j+1)*FP_WIDTH +: FP_WIDTH];
    end else begin : g_pad
      assign b = FP_ZERO;
    end
    adder_subtractor_with_start u_add (
      .clk(clk),
      .rst(rst),
      .start(start),
      .sub(1'b0),
      .a(ops[2*j*FP_WIDTH +: FP_WIDTH]),
      .b(b),
      .sum(sums[j*FP_WIDTH +: FP_WIDTH]),
      .finish(fin[j])
    );
  end
  assign level_done = &join_q;
  // sticky per-adder finish bits, only armed while the tree is active; cleared once all are in
  always_ff @(posedge clk or posedge rst)
    if (rst) join_q <= '0;
    else join_q <= level_done ? '0 : join_q | (fin & {M{en}});
endmodule

// File: rtl/fp_reduction_tree.sv
// fp_reduction_tree: NI-operand fp32 pairwise sum tree with optional multi-beat accumulation
module fp_reduction_tree
  import fp_reduce_pkg::*;
#(
  parameter int NI = 16,
  parameter bit ACC_EN = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   first,
  input  logic                   last,
  input  logic [NI*FP_WIDTH-1:0] inputs,
  output logic                   ready,
  output logic [FP_WIDTH-1:0]    summation,
  output logic                   finish,
  output logic                   finish_dash
);
  localparam int L = lvl_count(NI);
  state_t state, nxt;
  logic accept, root_done, acc_fin, acc_go, first_q, last_q, open_q, to_done;
  logic [FP_WIDTH-1:0] root, acc_sum, acc_q, res;
  assign accept = start && state == IDLE;
  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int W = lvl_width(NI, k);
    logic [W*FP_WIDTH-1:0] ops;
    logic [((W+1)/2)*FP_WIDTH-1:0] sums;
    logic go, done;
    if (k == 0) begin : g_in
      assign ops = inputs;
      assign go = accept;
    end else begin : g_in
      assign ops = g_lvl[k-1].sums;
      assign go = g_lvl[k-1].done;
    end
    reduction_level #(.N(W)) u_lvl (
      .clk(clk),
      .rst(rst),
      .start(go),
      .en(state == TREE),
      .ops(ops),
      .sums(sums),
      .level_done(done)
    );
  end
  assign root = g_lvl[L-1].sums;
  assign root_done = g_lvl[L-1].done;
  adder_subtractor_with_start u_acc (
    .clk(clk),
    .rst(rst),
    .start(acc_go),
    .sub(1'b0),
    .a(acc_q),
    .b(root),
    .sum(acc_sum),
    .finish(acc_fin)
  );
  assign to_done = nxt == DONE && state != DONE;
  assign res = (!ACC_EN || first_q) ? root : acc_sum;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next state: a first beat loads the accumulator in one ACC cycle, others wait for the accumulate adder
  always_comb
    nxt = state == IDLE ? (accept ? TREE : IDLE) :
          state == TREE ? (root_done ? (ACC_EN ? ACC : DONE) : TREE) :
          state == ACC  ? ((first_q || acc_fin) ? DONE : ACC) : IDLE;
  // outputs: finish only on the DONE cycle of a closing beat
  always_comb begin
    ready = state == IDLE;
    finish = state == DONE && last_q;
  end
  // beat flags, accumulator and result capture on entry to DONE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      first_q <= 1'b0;
      last_q <= 1'b0;
      open_q <= 1'b0;
      acc_go <= 1'b0;
      acc_q <= FP_ZERO;
      summation <= FP_ZERO;
      finish_dash <= 1'b0;
    end else begin
      if (accept) begin
        first_q <= !ACC_EN || first || !open_q;
        last_q <= !ACC_EN || last;
      end
      acc_go <= ACC_EN && state == TREE && root_done && !first_q;
      if (to_done) begin
        acc_q <= res;
        open_q <= !last_q;
        if (last_q) summation <= res;
      end
      finish_dash <= finish;
    end
endmodule
